// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and its width.
package serial_sub_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus a borrow flop.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// start_ready is high only in IDLE, done_valid only in DONE, and the result
// stays stable in DONE until done_ready is seen.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t state, next_state;

  logic [WIDTH-1:0] a_sh, b_sh, diff_r;
  logic             bin, borrow_r;
  logic [CW-1:0]    cnt;
  logic             bit_d, bit_bout;
  logic             start_fire, last_bit;

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bin),
    .d    (bit_d),
    .bout (bit_bout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b0;
    start_fire  = 1'b0;
    last_bit    = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        start_fire  = start_valid;
        if (start_valid) next_state = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        last_bit = (cnt == LAST_BIT);
        if (last_bit) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done_valid = 1'b1;
        if (done_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operands shift right, result bits enter diff from the MSB side.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      diff_r   <= '0;
      bin      <= 1'b0;
      borrow_r <= 1'b0;
      cnt      <= '0;
    end else if (start_fire) begin
      a_sh <= a;
      b_sh <= b;
      bin  <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      diff_r <= {bit_d, diff_r[WIDTH-1:1]};
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      bin    <= bit_bout;
      cnt    <= cnt + CW'(1);
      if (last_bit) borrow_r <= bit_bout;
    end
  end

  assign diff       = diff_r;
  assign borrow_out = borrow_r;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb, b_msb, ovf_r;

  // On the last bit, bit_d is the result MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_r <= 1'b0;
    end else if (start_fire) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (last_bit) begin
      ovf_r <= (a_msb != b_msb) && (bit_d != a_msb);
    end
  end

  assign ovf = ovf_r;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor: computes diff = a - b one bit per clock, LSB first, with a borrow flip-flop.
- Uses a single full-subtractor cell instead of a ripple chain; companion to the processor's full-adder datapath for area-constrained ALU paths.
- Operands enter via a valid/ready start handshake; the result leaves via a valid/ready done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low; the only clock is clk.
- start_valid  input  1  operands a/b valid.
- start_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend, sampled on start handshake.
- b  input  WIDTH  subtrahend, sampled on start handshake.
- diff  output  WIDTH  a - b modulo 2^WIDTH, registered.
- borrow_out  output  1  final borrow (1 when a < b unsigned).
- done_valid  output  1  diff/borrow_out valid.
- done_ready  input  1  consumer accepts result.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low at a rising clk edge):
  - State goes to IDLE; diff=0, borrow_out=0, done_valid=0, busy=0, start_ready=1.
  - Internal operand shift registers, borrow flop and bit counter are cleared.
  - Reset mid-RUN or in DONE aborts the operation and discards the result.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On an edge with start_valid&&start_ready: latch a and b, clear borrow flop, set counter=0, go to RUN.
- RUN, one bit per edge:
  - d = a0 ^ b0 ^ bin.
  - bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
  - Shift d into the diff register from the MSB side (right shift); right-shift the operand registers; bin <= bout; counter++.
  - After WIDTH bit-edges, go to DONE; borrow_out <= final bout; done_valid=1.
  - Counter width is $clog2(WIDTH)+1.
- Latency: with the start handshake at edge k, bits are processed at edges k+1..k+WIDTH, and done_valid rises after edge k+WIDTH.
- DONE:
  - diff, borrow_out and done_valid hold stable until an edge with done_ready=1, which returns the block to IDLE with done_valid=0.
  - diff and borrow_out keep their values until the next operation overwrites them.
  - Minimum turnaround is WIDTH+2 cycles per operation.
- start_valid outside IDLE is ignored: no overlap or queuing.
- done_ready asserted before done_valid has no effect.
- Bits are not externally visible during RUN; only the final value is defined.
- Edge cases: a=b gives diff 0, borrow 0. a<b wraps modulo 2^WIDTH with borrow 1. b=0 gives diff=a.

Optional Feature:
- Macro SERIAL_SUB_OVERFLOW_EN.
- When defined:
  - Extra output port ovf (1 bit), the signed two's-complement overflow.
  - ovf = (a_msb != b_msb) && (diff_msb != a_msb), using the original MSBs latched at start.
  - Registered alongside diff, valid with done_valid, cleared by reset.
- When undefined: the port and its latch registers are absent, and all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg: state enum (IDLE, RUN, DONE) and a 2-bit state-width constant.
- Sub-module full_subtractor: combinational a, b, bin -> d, bout; instantiated once.
- Top level contains the FSM, shift registers, counter, borrow flop and handshakes.

Test Plan (WIDTH=8):
- a=0x05, b=0x03, done_ready=1 -> diff=0x02, borrow_out=0, done_valid rises exactly 8 cycles after the accept edge.
- a=0x03, b=0x05 -> diff=0xFE, borrow_out=1. Then a=0xFF, b=0xFF -> diff=0x00, borrow_out=0.
- Backpressure: hold done_ready=0 for 5 cycles after done_valid, and pulse start_valid with a=0x10 -> diff stays stable, start_ready=0, new operands ignored. After done_ready=1, IDLE is reached and start_ready=1 on the next cycle.
- Reset: rst_n=0 at bit-cycle 4 of RUN -> next cycle all outputs 0, start_ready=1. A following 0x09-0x04 gives 0x05.
- Back-to-back: two operations with start_valid held high -> second accepted only after the first result is consumed. Results are 0x20-0x01=0x1F, then 0x00-0x01=0xFF with borrow 1.
- With SERIAL_SUB_OVERFLOW_EN: 0x80-0x01 -> diff=0x7F, ovf=1. 0x7F-0x01 -> ovf=0. 0x7F-0xFF -> diff=0x80, ovf=1.
